mem_apb_bridge: RTL and testbench

MEM_APB_BRIDGE -- requirements
Module: mem_apb_bridge

---
 rtl/mem_apb_pkg.sv | 17 +
 rtl/mem_apb_timeout.sv | 27 ++
 rtl/mem_apb_bridge.sv | 139 +++++++++++++
 tb/tb_mem_apb_bridge.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_apb_pkg.sv
// Shared types and constants for the memory-to-APB bridge.
package mem_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADDEAD;

endpackage

// File: rtl/mem_apb_timeout.sv
// ACCESS-phase wait counter; flags expiry on the LIMIT-th consecutive enabled cycle.
module mem_apb_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_count_en,
  output logic o_expired
);

  localparam int unsigned CntW = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;

  logic [CntW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_count_en) begin
      r_count <= r_count + CntW'(1);
    end else begin
      r_count <= '0;
    end
  end

  assign o_expired = i_count_en && (r_count == CntW'(LIMIT - 1));

endmodule

// File: rtl/mem_apb_bridge.sv
// Single-outstanding memory request to APB completer bridge.
// Optional ACCESS-phase timeout enabled by defining MEM_APB_BRIDGE_TIMEOUT_EN.
module mem_apb_bridge
  import mem_apb_pkg::*;
#(
  parameter int unsigned PADDR_W        = 7,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        mem_addr,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        mem_wr_data,
  input  logic [1:0]         mem_wr_width,
  output logic               mem_ready,
  output logic [31:0]        mem_rd_data,
  output logic               mem_err,
  output logic [PADDR_W-1:0] paddr,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [31:0]        pwdata,
  output logic [1:0]         psize,
  input  logic [31:0]        prdata,
  input  logic               pready,
  input  logic               pslverr
);

  state_e             r_state;
  state_e             w_state_next;
  logic [PADDR_W-1:0] r_addr;
  logic [31:0]        r_wdata;
  logic [1:0]         r_size;
  logic               r_write;
  logic               r_armed;
  logic               r_err;
  logic [31:0]        r_rd_data;
  logic               w_capture;
  logic               w_finish;
  logic               w_timeout;
  logic               w_unused;

  // Armed gating keeps a held level request from being issued twice.
  assign w_capture = (r_state == IDLE) && r_armed && (mem_read || mem_write);
  assign w_finish  = (r_state == ACCESS) && (pready || w_timeout);

`ifdef MEM_APB_BRIDGE_TIMEOUT_EN
  logic w_expired;

  mem_apb_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_count_en(r_state == ACCESS),
    .o_expired (w_expired)
  );

  assign w_timeout = w_expired && !pready;
  assign w_unused  = ^mem_addr[15:PADDR_W];
`else
  assign w_timeout = 1'b0;
  assign w_unused  = ^{mem_addr[15:PADDR_W], (TIMEOUT_CYCLES == 0)};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_capture) w_state_next = SETUP;
      SETUP:   w_state_next = ACCESS;
      ACCESS:  if (pready || w_timeout) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    psel      = 1'b0;
    penable   = 1'b0;
    mem_ready = 1'b0;
    mem_err   = 1'b0;
    unique case (r_state)
      SETUP:  psel = 1'b1;
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      DONE: begin
        mem_ready = 1'b1;
        mem_err   = r_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_size    <= '0;
      r_write   <= 1'b0;
      r_armed   <= 1'b1;
      r_err     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      if (w_capture) begin
        r_addr  <= mem_addr[PADDR_W-1:0];
        r_wdata <= mem_wr_data;
        r_write <= mem_write;
        r_size  <= mem_write ? mem_wr_width : SZ_WORD;
        r_armed <= 1'b0;
      end else if (!mem_read && !mem_write) begin
        r_armed <= 1'b1;
      end
      if (w_finish) begin
        r_err <= pready ? pslverr : 1'b1;
        if (!r_write) begin
          r_rd_data <= pready ? prdata : TIMEOUT_RDATA;
        end
      end
    end
  end

  assign paddr       = r_addr;
  assign pwrite      = r_write;
  assign pwdata      = r_wdata;
  assign psize       = r_size;
  assign mem_rd_data = r_rd_data;

endmodule

// File: tb/tb_mem_apb_bridge.sv
// Scoreboard bench for mem_apb_bridge: stimulus pushes expectations, negedge monitors check them.
module tb_mem_apb_bridge;

`ifdef MEM_APB_BRIDGE_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wr_data;
  logic [1:0]  mem_wr_width;
  logic        mem_ready;
  logic [31:0] mem_rd_data;
  logic        mem_err;
  logic [6:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [1:0]  psize;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  mem_apb_bridge #(
    .PADDR_W       (7),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_wr_data (mem_wr_data),
    .mem_wr_width(mem_wr_width),
    .mem_ready   (mem_ready),
    .mem_rd_data (mem_rd_data),
    .mem_err     (mem_err),
    .paddr       (paddr),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .psize       (psize),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          issue;
    int          lat;
  } rsp_t;

  typedef struct {
    logic [6:0]  addr;
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] wd;
    int          issue;
  } apb_t;

  rsp_t        rsp_q[$];
  apb_t        apb_q[$];
  rsp_t        mon_r;
  apb_t        cur_apb;
  int          errors    = 0;
  int          checks    = 0;
  int          ready_cnt = 0;
  int          cyc       = 0;
  int          acc_cnt   = 0;
  int          waits_cfg = 0;
  logic [31:0] prdata_cfg = '0;
  logic        serr_cfg   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Completer model: pready rises after waits_cfg ACCESS cycles.
  always @(posedge clk) acc_cnt <= (psel && penable) ? acc_cnt + 1 : 0;
  assign pready  = penable && (acc_cnt >= waits_cfg);
  assign prdata  = prdata_cfg;
  assign pslverr = serr_cfg;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_ready) begin
        ready_cnt++;
        if (rsp_q.size() == 0) begin
          check("unexpected_ready", {31'd0, mem_ready}, 32'd0);
        end else begin
          mon_r = rsp_q.pop_front();
          check("rd_data", mem_rd_data, mon_r.rd);
          check("mem_err", {31'd0, mem_err}, {31'd0, mon_r.err});
          check("latency", cyc - mon_r.issue, mon_r.lat);
        end
      end else begin
        check("err_idle", {31'd0, mem_err}, 32'd0);
      end
      if (psel && !penable) begin
        if (apb_q.size() == 0) begin
          check("unexpected_setup", {31'd0, psel}, 32'd0);
        end else begin
          cur_apb = apb_q.pop_front();
          check("setup_lat", cyc - cur_apb.issue, 32'd1);
          check("paddr", {25'd0, paddr}, {25'd0, cur_apb.addr});
          check("pwrite", {31'd0, pwrite}, {31'd0, cur_apb.wr});
          check("psize", {30'd0, psize}, {30'd0, cur_apb.sz});
          if (cur_apb.wr) check("pwdata", pwdata, cur_apb.wd);
        end
      end
      if (psel && penable) begin
        check("access_hold", {22'd0, paddr, pwrite, psize},
              {22'd0, cur_apb.addr, cur_apb.wr, cur_apb.sz});
      end
    end
  end

  task automatic xfer(input logic rd, input logic wr, input logic [15:0] addr,
                      input logic [31:0] wd, input logic [1:0] wid, input int waits,
                      input logic [31:0] rdata, input logic serr, input int hold,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int   start;
    apb_t a;
    rsp_t r;
    waits_cfg  = waits;
    prdata_cfg = rdata;
    serr_cfg   = serr;
    @(negedge clk);
    mem_read     = rd;
    mem_write    = wr;
    mem_addr     = addr;
    mem_wr_data  = wd;
    mem_wr_width = wid;
    a.addr  = addr[6:0];
    a.wr    = wr;
    a.sz    = wr ? wid : 2'd2;
    a.wd    = wd;
    a.issue = cyc;
    apb_q.push_back(a);
    r.rd    = exp_rd;
    r.err   = exp_err;
    r.issue = cyc;
    r.lat   = exp_lat;
    rsp_q.push_back(r);
    start = ready_cnt;
    repeat (hold) @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    for (int i = 0; i < 40 && ready_cnt == start; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("ready_pulses", ready_cnt - start, 32'd1);
    rsp_q.delete();
    apb_q.delete();
  endtask

  initial begin
    int start;
    apb_t a;
    rst          = 1'b1;
    mem_addr     = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_wr_data  = '0;
    mem_wr_width = '0;
    repeat (3) @(negedge clk);
    check("rst_psel", {31'd0, psel}, 32'd0);
    check("rst_penable", {31'd0, penable}, 32'd0);
    check("rst_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_err", {31'd0, mem_err}, 32'd0);
    check("rst_rd_data", mem_rd_data, 32'd0);
    check("rst_paddr", {25'd0, paddr}, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_psize_pwrite", {29'd0, psize, pwrite}, 32'd0);
    rst = 1'b0;

    xfer(1'b0, 1'b1, 16'h0004, 32'h12345678, 2'd2, 0, 32'h0, 1'b0, 1,
         32'h00000000, 1'b0, 3);
    xfer(1'b1, 1'b0, 16'h0010, 32'h0, 2'd2, 3, 32'hCAFEF00D, 1'b0, 1,
         32'hCAFEF00D, 1'b0, 6);
    xfer(1'b0, 1'b1, 16'h0085, 32'h000000AB, 2'd0, 1, 32'h0, 1'b1, 1,
         32'hCAFEF00D, 1'b1, 4);
    xfer(1'b1, 1'b0, 16'h0022, 32'h0, 2'd2, 0, 32'h11112222, 1'b0, 10,
         32'h11112222, 1'b0, 3);
    xfer(1'b1, 1'b1, 16'h0030, 32'h55AA55AA, 2'd1, 0, 32'hBAD0BAD0, 1'b0, 1,
         32'h11112222, 1'b0, 3);
    xfer(1'b1, 1'b0, 16'h007F, 32'h0, 2'd0, 0, 32'h0000FFFF, 1'b0, 1,
         32'h0000FFFF, 1'b0, 3);

    // Reset while the completer stalls in ACCESS.
    waits_cfg = 1000;
    @(negedge clk);
    mem_read = 1'b1;
    mem_addr = 16'h0040;
    a.addr  = 7'h40;
    a.wr    = 1'b0;
    a.sz    = 2'd2;
    a.wd    = '0;
    a.issue = cyc;
    apb_q.push_back(a);
    start = ready_cnt;
    @(negedge clk);
    mem_read = 1'b0;
    for (int i = 0; i < 10 && !penable; i++) @(negedge clk);
    check("stall_access", {31'd0, penable}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_psel", {31'd0, psel}, 32'd0);
    check("mid_rst_penable", {31'd0, penable}, 32'd0);
    check("mid_rst_ready", {31'd0, mem_ready}, 32'd0);
    check("mid_rst_rd_data", mem_rd_data, 32'd0);
    repeat (6) @(negedge clk);
    check("mid_rst_no_ready", ready_cnt - start, 32'd0);
    apb_q.delete();

    xfer(1'b1, 1'b0, 16'h0001, 32'h0, 2'd2, 2, 32'h87654321, 1'b0, 1,
         32'h87654321, 1'b0, 5);
`ifdef MEM_APB_BRIDGE_TIMEOUT_EN
    xfer(1'b1, 1'b0, 16'h0002, 32'h0, 2'd2, 1000, 32'h0, 1'b0, 1,
         32'hDEADDEAD, 1'b1, 10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
